// File: rtl/begin_alu_param.sv
// Multi-cycle signed ALU: add/sub, radix-4 Booth multiply, non-restoring divide.
// Start with BEGIN, single-cycle END pulse on completion; results hold until next start.
module begin_alu_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             BEGIN,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             ovf,
  output logic             dz,
  output logic             busy,
  output logic             END,
  output logic [2:0]       state_debug
);

  localparam int SW   = $clog2(WIDTH) + 1;
  localparam int HALF = WIDTH / 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ADDSUB = 3'd2,
    MUL    = 3'd3,
    DIV    = 3'd4,
    DIVFIX = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [SW-1:0]      step_q, step_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH:0]     mplr_q, mplr_d;
  logic [WIDTH+1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
  logic               ovf_q, ovf_d, dz_q, dz_d;

  // Shared add/sub adder: subtraction as opA + ~opB + 1 on sign-extended operands
  logic [WIDTH:0] as_sum;
  assign as_sum = {a_q[WIDTH-1], a_q}
                + ({b_q[WIDTH-1], b_q} ^ {(WIDTH+1){op_q[0]}})
                + {{WIDTH{1'b0}}, op_q[0]};

  // Booth radix-4 partial product from the low three multiplier bits
  logic [2:0]         booth;
  logic               pp_neg;
  logic [2*WIDTH-1:0] pp_mag, pp, mul_sum;
  always_comb begin
    booth  = mplr_q[2:0];
    pp_neg = booth[2] & ~(booth[1] & booth[0]);
    case (booth)
      3'b001, 3'b010, 3'b101, 3'b110: pp_mag = mcand_q;
      3'b011, 3'b100:                 pp_mag = {mcand_q[2*WIDTH-2:0], 1'b0};
      default:                        pp_mag = '0;
    endcase
    pp      = pp_neg ? ~pp_mag : pp_mag;
    mul_sum = acc_q + pp + {{(2*WIDTH-1){1'b0}}, pp_neg};
  end

  logic [WIDTH-1:0] abs_a, abs_b, rem_fix;
  logic [WIDTH+1:0] rem_sh, dvs_ext, div_sum;
  assign abs_a   = a_q[WIDTH-1] ? -a_q : a_q;
  assign abs_b   = b_q[WIDTH-1] ? -b_q : b_q;
  assign rem_sh  = {rem_q[WIDTH:0], quo_q[WIDTH-1]};
  assign dvs_ext = {2'b00, dvs_q};
  assign div_sum = rem_q[WIDTH+1] ? rem_sh + dvs_ext : rem_sh - dvs_ext;
  // Final remainder lies in [0, |opB|), so restoration fits in WIDTH bits
  assign rem_fix = rem_q[WIDTH-1:0] + (rem_q[WIDTH+1] ? dvs_q : '0);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    step_d  = step_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (BEGIN) begin
          op_d    = op_code;
          a_d     = opA;
          b_d     = opB;
          step_d  = '0;
          lo_d    = '0;
          hi_d    = '0;
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        step_d  = '0;
        acc_d   = '0;
        mcand_d = {{WIDTH{a_q[WIDTH-1]}}, a_q};
        mplr_d  = {b_q, 1'b0};
        rem_d   = '0;
        quo_d   = abs_a;
        dvs_d   = abs_b;
        case (op_q)
          2'b10: state_d = MUL;
          2'b11: begin
            if (b_q != '0) begin
              state_d = DIV;
            end else if (step_q == '0) begin
              // Divide-by-zero dwells one extra LOAD cycle to keep its 3-edge latency
              step_d = SW'(1);
            end else begin
              lo_d    = '1;
              hi_d    = a_q;
              dz_d    = 1'b1;
              state_d = DONE;
            end
          end
          default: state_d = ADDSUB;
        endcase
      end
      ADDSUB: begin
        lo_d    = as_sum[WIDTH-1:0];
        hi_d    = {WIDTH{as_sum[WIDTH-1]}};
        ovf_d   = as_sum[WIDTH] ^ as_sum[WIDTH-1];
        state_d = DONE;
      end
      MUL: begin
        if (step_q == SW'(HALF)) begin
          {hi_d, lo_d} = acc_q;
          state_d      = DONE;
        end else begin
          acc_d   = mul_sum;
          mcand_d = mcand_q << 2;
          mplr_d  = {{2{mplr_q[WIDTH]}}, mplr_q[WIDTH:2]};
          step_d  = step_q + SW'(1);
        end
      end
      DIV: begin
        if (step_q == SW'(WIDTH)) begin
          state_d = DIVFIX;
        end else begin
          rem_d  = div_sum;
          quo_d  = {quo_q[WIDTH-2:0], ~div_sum[WIDTH+1]};
          step_d = step_q + SW'(1);
        end
      end
      DIVFIX: begin
        lo_d    = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -quo_q : quo_q;
        hi_d    = a_q[WIDTH-1] ? -rem_fix : rem_fix;
        ovf_d   = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
        step_d  = '0;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      step_q  <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign result_lo   = lo_q;
  assign result_hi   = hi_q;
  assign ovf         = ovf_q;
  assign dz          = dz_q;
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign END         = (state_q == DONE);
  assign state_debug = state_q;

endmodule
